// File: rtl/soi_probe_bank_pkg.sv
// soi_probe_pkg: shared op/mode/FSM types for the SOI probe bank.  rev 1.0
`default_nettype none

package soi_probe_pkg;

   typedef enum logic [1:0] {READ_VAL, WRITE_VAL, WRITE_MODE, READ_STAT} soi_op_e;
   typedef enum logic [1:0] {HOLD, TOGGLE, COUNT, RSVD} soi_mode_e;
   typedef enum logic {IDLE, RESP} soi_fsm_e;

   localparam int STAT_WRAP_BIT = 2;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/soi_probe_bank_if.sv
// soi_probe_bank_if: host request/response handshake of the probe bank.  rev 1.0
`default_nettype none

interface soi_probe_bank_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
);
   import soi_probe_pkg::*;

   localparam int CH_W = ch_width(NUM_CH);

   logic              req_valid;
   logic              req_ready;
   soi_op_e           req_op;
   logic [CH_W-1:0]   req_ch;
   logic [WIDTH-1:0]  req_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_ch, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_ch, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

`default_nettype wire

// File: rtl/soi_probe_bank_ch.sv
// soi_probe_ch: one probe channel -- value, mode, sticky wrap and host override.  rev 1.0
`default_nettype none

module soi_probe_ch
   import soi_probe_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int RST_VAL  = 1,
   parameter int RST_MODE = 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             run,
   input  wire logic             wr_val,
   input  wire logic             wr_mode,
   input  wire logic             clr_wrap,
   input  wire logic [WIDTH-1:0] wr_data,
   input  wire soi_mode_e        wr_mode_data,
   output logic      [WIDTH-1:0] val,
   output soi_mode_e             mode,
   output logic                  wrap
);

   localparam logic [WIDTH-1:0] VAL_INIT  = WIDTH'(RST_VAL);
   localparam soi_mode_e        MODE_INIT = soi_mode_e'(2'(RST_MODE));

   logic [WIDTH-1:0] next_val;
   logic             wrap_set;

   // A host write replaces this cycle's free-run step, so it can never raise wrap.
   always_comb begin
      next_val = val;
      wrap_set = 1'b0;
      if (run) begin
         case (mode)
            TOGGLE:  next_val = ~val;
            COUNT: begin
               next_val = val + WIDTH'(1);
               wrap_set = &val;
            end
            default: next_val = val;
         endcase
      end
      if (wr_val) begin
         next_val = wr_data;
         wrap_set = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val  <= VAL_INIT;
         mode <= MODE_INIT;
         wrap <= 1'b0;
      end else begin
         val  <= next_val;
         wrap <= wrap_set | (wrap & ~clr_wrap);
         if (wr_mode) begin
            mode <= wr_mode_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/soi_probe_bank.sv
// soi_probe_bank: NUM_CH free-running probe channels behind a one-deep host handshake.  rev 1.0
`default_nettype none

module soi_probe_bank
   import soi_probe_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 8,
   parameter int RST_VAL  = 1,
   parameter int RST_MODE = 1
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    run,
   soi_probe_bank_if.slave              bus,
   output logic [NUM_CH*WIDTH-1:0]      ch_val,
   output logic [NUM_CH-1:0]            ch_wrap
);

   localparam int CH_W = ch_width(NUM_CH);

   soi_fsm_e                state;
   soi_fsm_e                state_next;
   logic                    accept;
   logic                    ch_ok;
   logic [WIDTH-1:0]        rd_data;
   logic [STAT_WRAP_BIT:0]  stat;
   logic [WIDTH-1:0]        rsp_data_q;
   logic                    rsp_err_q;
   logic [WIDTH-1:0]        vals  [NUM_CH];
   soi_mode_e               modes [NUM_CH];

   assign ch_ok = (32'(bus.req_ch) < 32'(NUM_CH));

   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read data is taken from pre-edge channel state; bad indices answer 0.
   always_comb begin
      rd_data = '0;
      stat    = '0;
      if (ch_ok) begin
         case (bus.req_op)
            READ_VAL:  rd_data = vals[bus.req_ch];
            READ_STAT: begin
               stat    = {ch_wrap[bus.req_ch], 2'(modes[bus.req_ch])};
               rd_data = WIDTH'(stat);
            end
            default:   rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            rsp_data_q <= rd_data;
            rsp_err_q  <= ~ch_ok;
         end
      end
   end

   assign bus.rsp_data = rsp_data_q;
   assign bus.rsp_err  = rsp_err_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;
      assign hit = accept & ch_ok & (bus.req_ch == CH_W'(i));

      soi_probe_ch #(
         .WIDTH    (WIDTH),
         .RST_VAL  (RST_VAL),
         .RST_MODE (RST_MODE)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .run          (run),
         .wr_val       (hit & (bus.req_op == WRITE_VAL)),
         .wr_mode      (hit & (bus.req_op == WRITE_MODE)),
         .clr_wrap     (hit & (bus.req_op == READ_STAT)),
         .wr_data      (bus.req_data),
         .wr_mode_data (soi_mode_e'(2'(bus.req_data))),
         .val          (vals[i]),
         .mode         (modes[i]),
         .wrap         (ch_wrap[i])
      );

      assign ch_val[i*WIDTH +: WIDTH] = vals[i];
   end

endmodule

`default_nettype wire

// File: tb/tb_soi_probe_bank.sv
// tb_soi_probe_bank: scenario tasks plus randomized traffic against a spec-level model.  rev 1.0
`default_nettype none

module tb_soi_probe_bank;
   import soi_probe_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   always #5 clk = ~clk;

   soi_probe_bank_if #(.NUM_CH(4), .WIDTH(8)) bus  ();
   soi_probe_bank_if #(.NUM_CH(3), .WIDTH(8)) bus3 ();

   logic [31:0] ch_val;
   logic [3:0]  ch_wrap;
   logic [23:0] ch_val3;
   logic [2:0]  ch_wrap3;

   soi_probe_bank #(.NUM_CH(4), .WIDTH(8), .RST_VAL(1), .RST_MODE(1)) dut (
      .clk(clk), .rst(rst), .run(run), .bus(bus), .ch_val(ch_val), .ch_wrap(ch_wrap)
   );

   soi_probe_bank #(.NUM_CH(3), .WIDTH(8), .RST_VAL(1), .RST_MODE(1)) dut3 (
      .clk(clk), .rst(rst), .run(run), .bus(bus3), .ch_val(ch_val3), .ch_wrap(ch_wrap3)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference state of the 4-channel bank
   logic [7:0] m_val  [4];
   logic [1:0] m_mode [4];
   logic       m_wrap [4];
   logic       m_pend;
   logic [7:0] m_rsp;
   logic       m_err;

   task automatic model_edge();
      logic [7:0] nv [4];
      logic [1:0] nm [4];
      logic       set [4];
      logic       clr [4];
      logic [1:0] op;
      int         ch;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_val[i] = 8'h01; m_mode[i] = 2'd1; m_wrap[i] = 1'b0;
         end
         m_pend = 1'b0; m_rsp = 8'h00; m_err = 1'b0;
         return;
      end
      op = bus.req_op;
      ch = int'(bus.req_ch);
      for (int i = 0; i < 4; i++) begin
         nv[i] = m_val[i]; nm[i] = m_mode[i]; set[i] = 1'b0; clr[i] = 1'b0;
         if (run && m_mode[i] == 2'd1) nv[i] = ~m_val[i];
         if (run && m_mode[i] == 2'd2) begin
            nv[i]  = 8'((int'(m_val[i]) + 1) % 256);
            set[i] = (m_val[i] == 8'hFF);
         end
      end
      if (!m_pend && bus.req_valid) begin
         m_pend = 1'b1; m_err = 1'b0; m_rsp = 8'h00;
         case (op)
            2'd0: m_rsp = m_val[ch];
            2'd1: begin nv[ch] = bus.req_data; set[ch] = 1'b0; end
            2'd2: nm[ch] = bus.req_data[1:0];
            default: begin
               m_rsp  = {5'd0, m_wrap[ch], m_mode[ch]};
               clr[ch] = 1'b1;
            end
         endcase
      end else if (m_pend && bus.rsp_ready) begin
         m_pend = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         m_val[i]  = nv[i];
         m_mode[i] = nm[i];
         m_wrap[i] = set[i] | (m_wrap[i] & ~clr[i]);
      end
   endtask

   function automatic logic [31:0] exp_vals();
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_val[i];
      return r;
   endfunction

   function automatic logic [3:0] exp_wraps();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = m_wrap[i];
      return r;
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic xact(input logic [1:0] op, input int ch, input logic [7:0] data,
                       output logic [7:0] rd, output logic err);
      bus.req_valid = 1'b1;
      bus.req_op    = soi_op_e'(op);
      bus.req_ch    = 2'(ch);
      bus.req_data  = data;
      bus.rsp_ready = 1'b0;
      tick();
      rd  = bus.rsp_data;
      err = bus.rsp_err;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_total++; if (ch_val[7:0] !== 8'h01) $display("FAIL reset_ch0: got %h want 01", ch_val[7:0]); else n_pass++;
      n_total++; if (ch_wrap !== 4'h0) $display("FAIL reset_wrap: got %h want 0", ch_wrap); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL reset_hs: ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid); else n_pass++;
      n_total++; if (bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) $display("FAIL reset_rsp: data %h err %b want 00 0", bus.rsp_data, bus.rsp_err); else n_pass++;
      tick();
      n_total++; if (ch_val[7:0] !== 8'hFE) $display("FAIL toggle_1: got %h want fe", ch_val[7:0]); else n_pass++;
      tick();
      n_total++; if (ch_val[7:0] !== 8'h01) $display("FAIL toggle_2: got %h want 01", ch_val[7:0]); else n_pass++;
      n_total++; if (ch_val !== exp_vals()) $display("FAIL reset_model: got %h want %h", ch_val, exp_vals()); else n_pass++;
   endtask

   task automatic test_count_wrap();
      logic [7:0] rd;
      logic       err;
      run = 1'b1;
      xact(2'd2, 2, 8'h02, rd, err);
      bus.req_valid = 1'b1; bus.req_op = WRITE_VAL; bus.req_ch = 2'd2; bus.req_data = 8'hFE;
      tick();
      n_total++; if (ch_val[23:16] !== 8'hFE) $display("FAIL count_fe: got %h want fe", ch_val[23:16]); else n_pass++;
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      n_total++; if (ch_val[23:16] !== 8'hFF) $display("FAIL count_ff: got %h want ff", ch_val[23:16]); else n_pass++;
      tick();
      n_total++; if (ch_val[23:16] !== 8'h00 || ch_wrap[2] !== 1'b1) $display("FAIL count_wrap: val %h wrap %b want 00 1", ch_val[23:16], ch_wrap[2]); else n_pass++;
      xact(2'd3, 2, 8'h00, rd, err);
      n_total++; if (rd !== 8'h06 || err !== 1'b0) $display("FAIL stat_first: got %h err %b want 06 0", rd, err); else n_pass++;
      xact(2'd3, 2, 8'h00, rd, err);
      n_total++; if (rd !== 8'h02) $display("FAIL stat_second: got %h want 02", rd); else n_pass++;
      n_total++; if (ch_val !== exp_vals() || ch_wrap !== exp_wraps()) $display("FAIL count_model: got %h/%h want %h/%h", ch_val, ch_wrap, exp_vals(), exp_wraps()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      run = 1'b1;
      bus.req_valid = 1'b1; bus.req_op = READ_VAL; bus.req_ch = 2'd1; bus.rsp_ready = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_total++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_data !== m_rsp)
            $display("FAIL stall_%0d: valid %b ready %b data %h want 1 0 %h", k, bus.rsp_valid, bus.req_ready, bus.rsp_data, m_rsp);
         else n_pass++;
         tick();
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_op = READ_VAL; bus.req_ch = 2'd3;
      tick();
      n_total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL retire_idle: valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready); else n_pass++;
      bus.rsp_ready = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== m_rsp) $display("FAIL next_accept: valid %b data %h want 1 %h", bus.rsp_valid, bus.rsp_data, m_rsp); else n_pass++;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_write_toggle();
      rst = 1'b1; tick(); rst = 1'b0;
      run = 1'b1;
      bus.req_valid = 1'b1; bus.req_op = WRITE_VAL; bus.req_ch = 2'd0; bus.req_data = 8'h5A;
      tick();
      n_total++; if (ch_val !== 32'hFEFEFE5A) $display("FAIL write_5a: got %h want fefefe5a", ch_val); else n_pass++;
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      n_total++; if (ch_val !== 32'h010101A5) $display("FAIL write_a5: got %h want 010101a5", ch_val); else n_pass++;
   endtask

   task automatic test_error();
      rst = 1'b1; run = 1'b0; tick(); rst = 1'b0;
      bus3.req_valid = 1'b1; bus3.req_op = WRITE_VAL; bus3.req_ch = 2'd3; bus3.req_data = 8'hAA;
      tick();
      bus3.req_valid = 1'b0;
      n_total++; if (bus3.rsp_valid !== 1'b1 || bus3.rsp_err !== 1'b1 || bus3.rsp_data !== 8'h00)
         $display("FAIL err_write: valid %b err %b data %h want 1 1 00", bus3.rsp_valid, bus3.rsp_err, bus3.rsp_data);
      else n_pass++;
      bus3.rsp_ready = 1'b1; tick(); bus3.rsp_ready = 1'b0;
      n_total++; if (ch_val3 !== 24'h010101 || ch_wrap3 !== 3'b000) $display("FAIL err_nochange: got %h/%b want 010101/000", ch_val3, ch_wrap3); else n_pass++;
      bus3.req_valid = 1'b1; bus3.req_op = READ_VAL; bus3.req_ch = 2'd2;
      tick();
      bus3.req_valid = 1'b0;
      n_total++; if (bus3.rsp_err !== 1'b0 || bus3.rsp_data !== 8'h01) $display("FAIL err_valid_ch: err %b data %h want 0 01", bus3.rsp_err, bus3.rsp_data); else n_pass++;
      bus3.rsp_ready = 1'b1; tick(); bus3.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd;
      logic       err;
      run = 1'b1;
      xact(2'd2, 2, 8'h02, rd, err);
      xact(2'd1, 2, 8'hFF, rd, err);
      n_total++; if (ch_wrap[2] !== 1'b1) $display("FAIL mid_wrap_set: got %b want 1", ch_wrap[2]); else n_pass++;
      bus.req_valid = 1'b1; bus.req_op = WRITE_MODE; bus.req_ch = 2'd1; bus.req_data = 8'h00;
      tick();
      bus.req_valid = 1'b0;
      n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_pending: got %b want 1", bus.rsp_valid); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0; run = 1'b0;
      n_total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL mid_drop: valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready); else n_pass++;
      n_total++; if (ch_val !== 32'h01010101 || ch_wrap !== 4'h0) $display("FAIL mid_state: got %h/%h want 01010101/0", ch_val, ch_wrap); else n_pass++;
      tick(); tick(); tick();
      n_total++; if (ch_val !== 32'h01010101) $display("FAIL freeze: got %h want 01010101", ch_val); else n_pass++;
      xact(2'd3, 1, 8'h00, rd, err);
      n_total++; if (rd !== 8'h01) $display("FAIL mid_mode: got %h want 01", rd); else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst           = ($urandom_range(0, 79) == 0);
         run           = ($urandom_range(0, 3) != 0);
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_op    = soi_op_e'(2'($urandom_range(0, 3)));
         bus.req_ch    = 2'($urandom_range(0, 3));
         bus.req_data  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) bus.req_data = 8'hFD + 8'($urandom_range(0, 2));
         bus.rsp_ready = 1'($urandom_range(0, 1));
         tick();
         n_total++; if (ch_val !== exp_vals() || ch_wrap !== exp_wraps())
            $display("FAIL rand_state c%0d: got %h/%h want %h/%h", c, ch_val, ch_wrap, exp_vals(), exp_wraps());
         else n_pass++;
         n_total++; if (bus.rsp_valid !== m_pend || bus.req_ready !== ~m_pend)
            $display("FAIL rand_hs c%0d: valid %b ready %b want %b %b", c, bus.rsp_valid, bus.req_ready, m_pend, ~m_pend);
         else n_pass++;
         if (m_pend) begin
            n_total++; if (bus.rsp_data !== m_rsp || bus.rsp_err !== m_err)
               $display("FAIL rand_rsp c%0d: data %h err %b want %h %b", c, bus.rsp_data, bus.rsp_err, m_rsp, m_err);
            else n_pass++;
         end
      end
      rst = 1'b0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0; bus.req_op  = READ_VAL; bus.req_ch  = 2'd0; bus.req_data  = 8'h00; bus.rsp_ready  = 1'b0;
      bus3.req_valid = 1'b0; bus3.req_op = READ_VAL; bus3.req_ch = 2'd0; bus3.req_data = 8'h00; bus3.rsp_ready = 1'b0;
      test_reset();
      test_count_wrap();
      test_back_to_back();
      test_write_toggle();
      test_error();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
